// File: rtl/cmdl_rx_m.sv
// cmdl_rx_m: command-link frame receiver.
// Receives 5-byte frames of the form HDR, MOD, ADDR, DATA, CHK. CHK is the
// 8-bit wrap-around sum of MOD, ADDR and DATA. A frame that passes the
// checksum is presented on cmdl_* with a one-cycle cmdl_vld strobe. A bad
// checksum or an inter-byte timeout produces a one-cycle error pulse.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | hunting for the header byte; every other byte is dropped
// S_MOD  | header seen; the next byte is the mode/module byte
// S_ADDR | the next byte is the register address
// S_DATA | the next byte is the write data
// S_CHK  | the next byte is the checksum, compared with the running sum
module cmdl_rx_m #(
  parameter logic [7:0]  HDR  = 8'h5A,
  parameter logic [15:0] TOUT = 16'd50000
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_vld,
  output logic [7:0]  cmdl_mod,
  output logic [7:0]  cmdl_addr,
  output logic [7:0]  cmdl_data,
  output logic        cmdl_vld,
  output logic        busy,
  output logic        err_chk,
  output logic        err_tout,
  output logic [15:0] cnt_ok,
  output logic [15:0] cnt_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MOD  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_CHK  = 3'd4
  } state_t;

  // Terminal count of the inter-byte timer.
  localparam logic [15:0] TOUT_TC = TOUT - 16'd1;

  state_t      state_q, state_d;
  logic [7:0]  sum_q;
  logic [7:0]  sh_mod_q, sh_addr_q, sh_data_q;
  logic [15:0] tcnt_q;
  logic        frm_ok, frm_bad, tout_fire;

  // State register.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and frame verdicts. An arriving byte always has
  // priority over a timeout firing in the same cycle.
  always_comb begin
    state_d   = state_q;
    frm_ok    = 1'b0;
    frm_bad   = 1'b0;
    tout_fire = 1'b0;
    if (rx_vld) begin
      case (state_q)
        S_IDLE:  if (rx_data == HDR) state_d = S_MOD;
        S_MOD:   state_d = S_ADDR;
        S_ADDR:  state_d = S_DATA;
        S_DATA:  state_d = S_CHK;
        S_CHK: begin
          state_d = S_IDLE;
          if (sum_q == rx_data) frm_ok  = 1'b1;
          else                  frm_bad = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && tcnt_q == TOUT_TC) begin
      tout_fire = 1'b1;
      state_d   = S_IDLE;
    end
  end

  // Shadow registers and running sum. Payload bytes are not examined, so a
  // header value inside the payload is ordinary data.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= 8'h00;
      sh_mod_q  <= 8'h00;
      sh_addr_q <= 8'h00;
      sh_data_q <= 8'h00;
    end else if (rx_vld) begin
      case (state_q)
        S_IDLE: if (rx_data == HDR) sum_q <= 8'h00;
        S_MOD: begin
          sh_mod_q <= rx_data;
          sum_q    <= sum_q + rx_data;
        end
        S_ADDR: begin
          sh_addr_q <= rx_data;
          sum_q     <= sum_q + rx_data;
        end
        S_DATA: begin
          sh_data_q <= rx_data;
          sum_q     <= sum_q + rx_data;
        end
        default: ;
      endcase
    end
  end

  // Inter-byte timer: counts silent cycles while a frame is in progress.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)                                       tcnt_q <= 16'd0;
    else if (rx_vld || state_q == S_IDLE || tout_fire) tcnt_q <= 16'd0;
    else                                              tcnt_q <= tcnt_q + 16'd1;
  end

  // Command outputs and one-cycle status pulses, registered one cycle after
  // the deciding byte or timeout.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cmdl_mod  <= 8'h00;
      cmdl_addr <= 8'h00;
      cmdl_data <= 8'h00;
      cmdl_vld  <= 1'b0;
      err_chk   <= 1'b0;
      err_tout  <= 1'b0;
    end else begin
      cmdl_vld <= frm_ok;
      err_chk  <= frm_bad;
      err_tout <= tout_fire;
      if (frm_ok) begin
        cmdl_mod  <= sh_mod_q;
        cmdl_addr <= sh_addr_q;
        cmdl_data <= sh_data_q;
      end
    end
  end

  // Saturating frame counters; a checksum error and a timeout cannot both
  // occur in one cycle, and the error counter steps by one regardless.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ok  <= 16'd0;
      cnt_err <= 16'd0;
    end else begin
      if (frm_ok && cnt_ok != 16'hFFFF)                   cnt_ok  <= cnt_ok + 16'd1;
      if ((frm_bad || tout_fire) && cnt_err != 16'hFFFF) cnt_err <= cnt_err + 16'd1;
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule
